// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int unsigned DIV_MIN   = 2;
    localparam int unsigned DIV_W_MAX = 32;

    typedef logic [DIV_W_MAX-1:0] cfg_word_t;

    // Per-channel configuration record: divisor, start phase and pending flag.
    typedef struct packed {
        cfg_word_t div;
        cfg_word_t phase;
        logic      pending;
    } chan_cfg_t;

    // Divisors below DIV_MIN cannot produce a high and a low phase.
    function automatic cfg_word_t clamp_div(input cfg_word_t d);
        return (d < cfg_word_t'(DIV_MIN)) ? cfg_word_t'(DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, shadow configuration and registered output decode.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 10
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DIV_W-1:0] cfg_phase,
    output logic             cfg_ack,
    output logic             outclk,
    output logic             tick
);

    logic [DIV_W-1:0] cnt, cnt_n;
    cfg_word_t        cur_div, cur_div_n;
    cfg_word_t        cur_phase, cur_phase_n;
    chan_cfg_t        sh, sh_n;
    logic             en_q;
    logic             ack_n, outclk_n, tick_n;
    cfg_word_t        start_cnt;

    // Next-state: counting, config hand-over and output decode of the next cycle.
    always_comb begin
        cnt_n       = cnt;
        cur_div_n   = cur_div;
        cur_phase_n = cur_phase;
        sh_n        = sh;
        ack_n       = 1'b0;
        start_cnt   = (cur_phase < cur_div - 1) ? cur_phase : cur_div - 1;

        if (!en) begin
            // An idle channel takes a write directly; same result as shadow-then-apply.
            cnt_n = '0;
            if (cfg_we) begin
                cur_div_n    = clamp_div(cfg_word_t'(cfg_div));
                cur_phase_n  = cfg_word_t'(cfg_phase);
                sh_n.pending = 1'b0;
                ack_n        = 1'b1;
            end else if (sh.pending) begin
                cur_div_n    = sh.div;
                cur_phase_n  = sh.phase;
                sh_n.pending = 1'b0;
                ack_n        = 1'b1;
            end
        end else begin
            if (!en_q) begin
                cnt_n = DIV_W'(start_cnt);
            end else if (cfg_word_t'(cnt) >= cur_div - 1) begin
                cnt_n = '0;
                if (sh.pending) begin
                    cur_div_n    = sh.div;
                    cur_phase_n  = sh.phase;
                    sh_n.pending = 1'b0;
                    ack_n        = 1'b1;
                end
            end else begin
                cnt_n = cnt + DIV_W'(1);
            end
            // Applied after the wrap hand-over so a coinciding write stays pending.
            if (cfg_we) begin
                sh_n.div     = clamp_div(cfg_word_t'(cfg_div));
                sh_n.phase   = cfg_word_t'(cfg_phase);
                sh_n.pending = 1'b1;
            end
        end

        outclk_n = en && (cfg_word_t'(cnt_n) < (cur_div_n >> 1));
        tick_n   = en && (cnt_n == '0);
    end

    // Channel state and registered outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            cur_div   <= clamp_div(cfg_word_t'(DEFAULT_DIV));
            cur_phase <= '0;
            sh        <= '0;
            en_q      <= 1'b0;
            cfg_ack   <= 1'b0;
            outclk    <= 1'b0;
            tick      <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            cur_div   <= cur_div_n;
            cur_phase <= cur_phase_n;
            sh        <= sh_n;
            en_q      <= en;
            cfg_ack   <= ack_n;
            outclk    <= outclk_n;
            tick      <= tick_n;
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with shadowed config and lock indication.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CLOCKS  = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 10,
    parameter int unsigned LOCK_CYCLES = 16,
    localparam int unsigned SEL_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic [NUM_CLOCKS-1:0] en,
    input  logic                  cfg_we,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [DIV_W-1:0]      cfg_phase,
    output logic [NUM_CLOCKS-1:0] cfg_ack,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] tick,
    output logic                  locked
);

    localparam int unsigned STAB_W = $clog2(LOCK_CYCLES + 2);

    logic                  rst_meta, rst_sync;
    logic [NUM_CLOCKS-1:0] we_vec;
    logic [NUM_CLOCKS-1:0] en_prev;
    logic [STAB_W-1:0]     stab, stab_n;

    // Reset synchroniser: asserts immediately, releases after two refclk edges.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    // Write decode; selects beyond the last channel match nothing.
    always_comb begin
        we_vec = '0;
        if (cfg_we) begin
            for (int unsigned i = 0; i < NUM_CLOCKS; i++) begin
                if (cfg_sel == SEL_W'(i)) begin
                    we_vec[i] = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
            clkdiv_chan #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .refclk    (refclk),
                .rst_n     (rst_sync),
                .en        (en[g]),
                .cfg_we    (we_vec[g]),
                .cfg_div   (cfg_div),
                .cfg_phase (cfg_phase),
                .cfg_ack   (cfg_ack[g]),
                .outclk    (outclk[g]),
                .tick      (tick[g])
            );
        end
    endgenerate

    // Stability counter: restarts on any ack or enable change, saturates at LOCK_CYCLES.
    always_comb begin
        stab_n = stab;
        if ((|cfg_ack) || (en != en_prev)) begin
            stab_n = '0;
        end else if (stab < STAB_W'(LOCK_CYCLES)) begin
            stab_n = stab + STAB_W'(1);
        end
    end

    // Lock state registers.
    always_ff @(posedge refclk or negedge rst_sync) begin
        if (!rst_sync) begin
            stab    <= '0;
            en_prev <= '0;
            locked  <= 1'b0;
        end else begin
            stab    <= stab_n;
            en_prev <= en;
            locked  <= (stab_n == STAB_W'(LOCK_CYCLES));
        end
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: table of per-channel divisor cases plus hand sequences.
module tb_clkdiv_multi;

    logic        refclk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_div;
    logic [15:0] cfg_phase;
    logic [3:0]  cfg_ack;
    logic [3:0]  outclk;
    logic [3:0]  tick;
    logic        locked;

    int total = 0;
    int bad   = 0;

    clkdiv_multi #(
        .NUM_CLOCKS  (4),
        .DIV_W       (16),
        .DEFAULT_DIV (10),
        .LOCK_CYCLES (16)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .en        (en),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_ack   (cfg_ack),
        .outclk    (outclk),
        .tick      (tick),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        int unsigned ch;
        int unsigned div;
        int unsigned phase;
        int unsigned first;
        int unsigned high;
        int unsigned period;
    } vec_t;

    vec_t vt [7];

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(input int unsigned ch, input int unsigned limit, output int unsigned n);
        n = 0;
        while (!tick[ch] && n < limit) begin
            cyc();
            n++;
        end
    endtask

    // From a tick cycle: count high cycles and cycles until the next tick.
    task automatic measure(input int unsigned ch, output int unsigned hi, output int unsigned len);
        hi  = 0;
        len = 0;
        do begin
            hi += outclk[ch];
            cyc();
            len++;
        end while (!tick[ch] && len < 64);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, hi, len, acks;
        vt[0] = '{3, 10, 0, 1, 5, 10};
        vt[1] = '{3,  3, 0, 1, 1,  3};
        vt[2] = '{3,  0, 0, 1, 1,  2};
        vt[3] = '{3,  1, 0, 1, 1,  2};
        vt[4] = '{2,  8, 4, 5, 4,  8};
        vt[5] = '{3,  7, 9, 2, 3,  7};
        vt[6] = '{2,  5, 2, 4, 2,  5};

        rst = 1'b0; en = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_div = '0; cfg_phase = '0;
        cyc(3);
        check("rst_outclk", outclk, 0);
        check("rst_tick", tick, 0);
        check("rst_ack", cfg_ack, 0);
        check("rst_locked", locked, 0);

        // Release with ch0 enabled: first tick three edges later, lock 16 quiet cycles after.
        en = 4'b0001;
        cyc();
        rst = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            cyc();
            if (k == 2) check("rel_tick_early", tick[0], 0);
            if (k == 3) begin
                check("rel_tick_first", tick[0], 1);
                check("rel_outclk_first", outclk[0], 1);
            end
            if (k == 18) check("rel_locked_early", locked, 0);
            if (k == 19) check("rel_locked", locked, 1);
        end
        wait_tick(0, 20, n);
        check("ch0_tick_found", tick[0], 1);
        measure(0, hi, len);
        check("ch0_high", hi, 5);
        check("ch0_period", len, 10);

        // Table: idle-channel write, enable with phase, period/duty, then disable.
        for (int i = 0; i < 7; i++) begin
            cfg_sel = 2'(vt[i].ch); cfg_div = 16'(vt[i].div); cfg_phase = 16'(vt[i].phase);
            cfg_we = 1'b1;
            cyc();
            cfg_we = 1'b0;
            check($sformatf("v%0d_ack", i), cfg_ack[vt[i].ch], 1);
            cyc();
            check($sformatf("v%0d_ack_off", i), cfg_ack[vt[i].ch], 0);
            en[vt[i].ch] = 1'b1;
            wait_tick(vt[i].ch, 40, n);
            check($sformatf("v%0d_first", i), n, vt[i].first);
            measure(vt[i].ch, hi, len);
            check($sformatf("v%0d_high", i), hi, vt[i].high);
            check($sformatf("v%0d_period", i), len, vt[i].period);
            en[vt[i].ch] = 1'b0;
            cyc();
            check($sformatf("v%0d_dis_outclk", i), outclk[vt[i].ch], 0);
            check($sformatf("v%0d_dis_tick", i), tick[vt[i].ch], 0);
            cyc(3);
            check($sformatf("v%0d_dis_hold", i), outclk[vt[i].ch], 0);
        end

        // ch1 running at 10: write div=3 at cnt=4, period completes, ack at wrap.
        en = 4'b0011;
        cyc(20);
        wait_tick(1, 20, n);
        check("b_tick", tick[1], 1);
        check("b_locked_before", locked, 1);
        cyc(4);
        cfg_sel = 2'd1; cfg_div = 16'd3; cfg_phase = 16'd0; cfg_we = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            cfg_we = 1'b0;
            if (k < 6) check($sformatf("b_noack_%0d", k), cfg_ack[1], 0);
        end
        check("b_ack_wrap", cfg_ack[1], 1);
        check("b_tick_wrap", tick[1], 1);
        check("b_locked_at_ack", locked, 1);
        for (int j = 1; j <= 6; j++) begin
            cyc();
            check($sformatf("b_outclk_%0d", j), outclk[1], (j % 3 == 0) ? 1 : 0);
            check($sformatf("b_tick_%0d", j), tick[1], (j % 3 == 0) ? 1 : 0);
            if (j == 1) check("b_locked_drop", locked, 0);
        end
        cyc(10);
        check("b_locked_still_low", locked, 0);
        cyc();
        check("b_locked_back", locked, 1);

        // ch0: back-to-back writes 6 then 4 in one period, single ack, period 4.
        wait_tick(0, 20, n);
        check("c_tick", tick[0], 1);
        cyc();
        cfg_sel = 2'd0; cfg_div = 16'd6; cfg_we = 1'b1;
        cyc();
        cfg_div = 16'd4;
        cyc();
        cfg_we = 1'b0;
        acks = 0;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            acks += cfg_ack[0];
        end
        check("c_ack_wrap", cfg_ack[0], 1);
        check("c_tick_wrap", tick[0], 1);
        check("c_ack_count", acks, 1);
        measure(0, hi, len);
        check("c_high", hi, 2);
        check("c_period", len, 4);

        // ch0: write landing on the wrap cycle applies the earlier shadow, new one waits.
        cyc();
        cfg_div = 16'd6; cfg_we = 1'b1;
        cyc();
        cfg_we = 1'b0;
        cyc();
        cfg_div = 16'd2; cfg_we = 1'b1;
        cyc();
        cfg_we = 1'b0;
        check("d_ack_first", cfg_ack[0], 1);
        check("d_tick_first", tick[0], 1);
        measure(0, hi, len);
        check("d_high6", hi, 3);
        check("d_period6", len, 6);
        check("d_ack_second", cfg_ack[0], 1);
        measure(0, hi, len);
        check("d_high2", hi, 1);
        check("d_period2", len, 2);
        check("d_ack_none", cfg_ack[0], 0);

        // Reset mid-period with a pending write: outputs clear at once, no ack, div back to 10.
        cyc();
        cfg_div = 16'd6; cfg_we = 1'b1;
        cyc();
        cfg_we = 1'b0;
        check("e_tick_before", tick[0], 1);
        #2 rst = 1'b0;
        #1;
        check("e_outclk", outclk, 0);
        check("e_tick", tick, 0);
        check("e_ack", cfg_ack, 0);
        check("e_locked", locked, 0);
        cyc(2);
        rst = 1'b1;
        acks = 0;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            acks += cfg_ack[0];
        end
        check("e_tick_restart", tick[0], 1);
        measure(0, hi, len);
        acks += cfg_ack[0];
        check("e_high", hi, 5);
        check("e_period", len, 10);
        check("e_no_ack", acks, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
